program_counter_ras: RTL and testbench

//  Next-generation program counter: parametrised width, sync clear, absolute load, increment,

---
 rtl/program_counter_ras_pkg.sv | 22 ++
 rtl/program_counter_ras_stack.sv | 59 +++++
 rtl/program_counter_ras.sv | 114 +++++++++++
 tb/tb_program_counter_ras.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/program_counter_ras_pkg.sv
// Shared defaults and the decoded-action type for the fetch-stage program counter.
// Optional feature macro used by this slice: PC_REL_BRANCH_EN (relative load via PC_Rel).
package program_counter_ras_pkg;

    localparam int DEF_ADDR_WIDTH   = 8;
    localparam int DEF_STACK_DEPTH  = 4;
    localparam int DEF_RESET_VECTOR = 0;
    localparam int NUM_PC_RAS_TEST  = 400;

    // One action wins per edge; OVF/UNF are rejected CALL/RET that only set the error flag.
    typedef enum logic [2:0] {
        ACT_HOLD = 3'd0,
        ACT_CLR  = 3'd1,
        ACT_RET  = 3'd2,
        ACT_CALL = 3'd3,
        ACT_LOAD = 3'd4,
        ACT_INC  = 3'd5,
        ACT_OVF  = 3'd6,
        ACT_UNF  = 3'd7
    } pc_act_e;

endpackage

// File: rtl/program_counter_ras_stack.sv
// Return-address LIFO: async reset and sync clear empty it; entries themselves are never reset.
// Push when full and pop when empty are ignored here; the caller flags them as errors.
module ras_stack #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] data_out,
    output logic         full,
    output logic         empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [CW-1:0] C_MAX = CW'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_top_cnt;
    logic [IW-1:0] w_wr_idx;
    logic [IW-1:0] w_rd_idx;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (r_count == C_MAX);
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign w_top_cnt = r_count - ONE;
    assign w_wr_idx  = r_count[IW-1:0];
    assign w_rd_idx  = w_top_cnt[IW-1:0];
    // The index is meaningless while empty, so only valid entries ever reach the output.
    assign data_out  = empty ? '0 : r_mem[w_rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (w_do_push) begin
            r_count <= r_count + ONE;
        end else if (w_do_pop) begin
            r_count <= w_top_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr && w_do_push) begin
            r_mem[w_wr_idx] <= data_in;
        end
    end

endmodule

// File: rtl/program_counter_ras.sv
// Fetch-stage PC with load/increment and CALL/RETURN through a return-address stack.
// Define PC_REL_BRANCH_EN to add PC_Rel, turning PC_Load into a PC-relative branch when set.
module program_counter_ras
    import program_counter_ras_pkg::*;
#(
    parameter int                   ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int                   STACK_DEPTH  = DEF_STACK_DEPTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(DEF_RESET_VECTOR)
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  PC_Clr,
    input  logic                  PC_Load,
    input  logic                  PC_Inc,
    input  logic                  PC_Call,
    input  logic                  PC_Ret,
`ifdef PC_REL_BRANCH_EN
    input  logic                  PC_Rel,
`endif
    input  logic [ADDR_WIDTH-1:0] Dest_Reg,
    output logic [ADDR_WIDTH-1:0] PC_Out,
    output logic                  Stack_Full,
    output logic                  Stack_Empty,
    output logic                  Stack_Err
);

    localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_err;
    pc_act_e               w_act;
    logic [ADDR_WIDTH-1:0] w_pc_plus1;
    logic [ADDR_WIDTH-1:0] w_load_target;
    logic [ADDR_WIDTH-1:0] w_ret_addr;
    logic [ADDR_WIDTH-1:0] w_next_pc;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_clr;

    assign w_pc_plus1 = r_pc + PC_ONE;

`ifdef PC_REL_BRANCH_EN
    assign w_load_target = PC_Rel ? (r_pc + Dest_Reg) : Dest_Reg;
`else
    assign w_load_target = Dest_Reg;
`endif

    always_comb begin
        w_act = ACT_HOLD;
        if (PC_Clr) begin
            w_act = ACT_CLR;
        end else if (PC_Ret) begin
            w_act = w_empty ? ACT_UNF : ACT_RET;
        end else if (PC_Call) begin
            w_act = w_full ? ACT_OVF : ACT_CALL;
        end else if (PC_Load) begin
            w_act = ACT_LOAD;
        end else if (PC_Inc) begin
            w_act = ACT_INC;
        end
    end

    always_comb begin
        w_next_pc = r_pc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_clr     = 1'b0;
        case (w_act)
            ACT_CLR:  begin w_next_pc = RESET_VECTOR; w_clr = 1'b1; end
            ACT_RET:  begin w_next_pc = w_ret_addr;   w_pop = 1'b1; end
            ACT_CALL: begin w_next_pc = Dest_Reg;     w_push = 1'b1; end
            ACT_LOAD: w_next_pc = w_load_target;
            ACT_INC:  w_next_pc = w_pc_plus1;
            default:  w_next_pc = r_pc;
        endcase
    end

    ras_stack #(
        .W     (ADDR_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_ras (
        .clk      (Clk),
        .rst      (Rst),
        .clr      (w_clr),
        .push     (w_push),
        .pop      (w_pop),
        .data_in  (w_pc_plus1),
        .data_out (w_ret_addr),
        .full     (w_full),
        .empty    (w_empty)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_pc  <= RESET_VECTOR;
            r_err <= 1'b0;
        end else begin
            r_pc <= w_next_pc;
            if (w_act == ACT_CLR) begin
                r_err <= 1'b0;
            end else if (w_act == ACT_OVF || w_act == ACT_UNF) begin
                r_err <= 1'b1;
            end
        end
    end

    assign PC_Out      = r_pc;
    assign Stack_Full  = w_full;
    assign Stack_Empty = w_empty;
    assign Stack_Err   = r_err;

endmodule

// File: tb/tb_program_counter_ras.sv
// Directed scenarios plus random strobes, checked against a queue-based model of the PC and RAS.
module tb_program_counter_ras;
  import program_counter_ras_pkg::*;

  localparam int W = 8;
  localparam int DEPTH = 4;
  localparam logic [W-1:0] RV = '0;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic pc_clr, pc_load, pc_inc, pc_call, pc_ret, pc_rel;
  logic [W-1:0] dest_reg;
  logic [W-1:0] pc_out;
  logic stack_full, stack_empty, stack_err;

  program_counter_ras #(.ADDR_WIDTH(W), .STACK_DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
    .Clk         (clk),
    .Rst         (rst),
    .PC_Clr      (pc_clr),
    .PC_Load     (pc_load),
    .PC_Inc      (pc_inc),
    .PC_Call     (pc_call),
    .PC_Ret      (pc_ret),
`ifdef PC_REL_BRANCH_EN
    .PC_Rel      (pc_rel),
`endif
    .Dest_Reg    (dest_reg),
    .PC_Out      (pc_out),
    .Stack_Full  (stack_full),
    .Stack_Empty (stack_empty),
    .Stack_Err   (stack_err)
  );

  // scoreboard / reference model
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_pc;
  logic exp_err;
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_pc"}, 32'(pc_out), 32'(exp_pc));
    check({tag, "_full"}, 32'(stack_full), 32'(exp_q.size() == DEPTH));
    check({tag, "_empty"}, 32'(stack_empty), 32'(exp_q.size() == 0));
    check({tag, "_err"}, 32'(stack_err), 32'(exp_err));
  endtask

  task automatic model_reset();
    exp_pc = RV;
    exp_q.delete();
    exp_err = 1'b0;
  endtask

  // Rules straight from the behaviour description: priority, then push/pop on the queue.
  task automatic model_step(input logic c, input logic r, input logic ca, input logic l,
                            input logic i, input logic rel, input logic [W-1:0] d);
    logic use_rel;
`ifdef PC_REL_BRANCH_EN
    use_rel = rel;
`else
    use_rel = 1'b0;
`endif
    if (c) model_reset();
    else if (r) begin
      if (exp_q.size() == 0) exp_err = 1'b1;
      else exp_pc = exp_q.pop_back();
    end else if (ca) begin
      if (exp_q.size() == DEPTH) exp_err = 1'b1;
      else begin
        exp_q.push_back(W'(exp_pc + 1));
        exp_pc = d;
      end
    end else if (l) exp_pc = use_rel ? W'(exp_pc + d) : d;
    else if (i) exp_pc = W'(exp_pc + 1);
  endtask

  // driver: apply strobes, clock once, advance the model, compare 1 ns after the edge
  task automatic step(input string tag, input logic c, input logic r, input logic ca,
                      input logic l, input logic i, input logic rel, input logic [W-1:0] d);
    pc_clr = c; pc_ret = r; pc_call = ca; pc_load = l; pc_inc = i; pc_rel = rel; dest_reg = d;
    @(posedge clk);
    #1;
    model_step(c, r, ca, l, i, rel, d);
    pc_clr = 0; pc_ret = 0; pc_call = 0; pc_load = 0; pc_inc = 0; pc_rel = 0;
    dest_reg = W'($urandom);
    check_all(tag);
  endtask

  task automatic do_load(input logic [W-1:0] d); step("load", 0, 0, 0, 1, 0, 0, d); endtask
  task automatic do_call(input logic [W-1:0] d); step("call", 0, 0, 1, 0, 0, 0, d); endtask
  task automatic do_ret();  step("ret", 0, 1, 0, 0, 0, 0, W'($urandom)); endtask
  task automatic do_inc();  step("inc", 0, 0, 0, 0, 1, 0, W'($urandom)); endtask
  task automatic do_clr();  step("clr", 1, 0, 0, 0, 0, 0, W'($urandom)); endtask

  initial begin
    rst = 1'b1;
    pc_clr = 0; pc_load = 0; pc_inc = 0; pc_call = 0; pc_ret = 0; pc_rel = 0;
    dest_reg = '0;
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b0;

    // async reset mid-run with three entries pushed
    do_call(8'h30); do_call(8'h31); do_call(8'h41); do_inc();
    check("t1_pre_pc", 32'(pc_out), 32'h42);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("t1_rst");
    check("t1_pc_lit", 32'(pc_out), 32'h00);
    #2 rst = 1'b0;
    do_ret();
    check("t1_unf_err", 32'(stack_err), 32'h1);
    do_clr();

    // nested call/return
    do_load(8'h10);
    do_call(8'h80); check("t2_pc0", 32'(pc_out), 32'h80);
    do_call(8'hA0); check("t2_pc1", 32'(pc_out), 32'hA0);
    do_ret();       check("t2_pc2", 32'(pc_out), 32'h81);
    do_ret();       check("t2_pc3", 32'(pc_out), 32'h11);
    check("t2_empty", 32'(stack_empty), 32'h1);

    // overflow then full unwind
    do_load(8'h00);
    do_call(8'h10); do_call(8'h20); do_call(8'h30); do_call(8'h40);
    do_call(8'h55);
    check("t3_hold", 32'(pc_out), 32'h40);
    check("t3_full", 32'(stack_full), 32'h1);
    check("t3_err", 32'(stack_err), 32'h1);
    do_ret(); do_ret(); do_ret(); do_ret();
    check("t3_unwound", 32'(pc_out), 32'h01);

    // underflow holds PC, clear drops the error
    do_clr();
    do_load(8'h20);
    do_ret();
    check("t4_pc", 32'(pc_out), 32'h20);
    check("t4_err", 32'(stack_err), 32'h1);
    do_clr();
    check("t4_clr_err", 32'(stack_err), 32'h0);

    // wrap-around and clear priority
    do_load(8'hFF); do_inc();
    check("t5_inc_wrap", 32'(pc_out), 32'h00);
    do_load(8'hFF); do_call(8'h30); do_ret();
    check("t5_call_wrap", 32'(pc_out), 32'h00);
    do_call(8'h77); do_ret(); do_ret();
    step("t5_all", 1, 1, 1, 1, 1, 1, 8'h99);
    check("t5_all_pc", 32'(pc_out), 32'h00);

`ifdef PC_REL_BRANCH_EN
    do_load(8'h10);
    step("t6_rel_back", 0, 0, 0, 1, 0, 1, 8'hFE);
    check("t6_rel_back_pc", 32'(pc_out), 32'h0E);
    do_load(8'hF0);
    step("t6_rel_wrap", 0, 0, 0, 1, 0, 1, 8'h20);
    check("t6_rel_wrap_pc", 32'(pc_out), 32'h10);
`endif

    // random strobes; clear kept rare so the stack reaches full and empty often
    for (int n = 0; n < NUM_PC_RAS_TEST; n++) begin
      step("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0),
           ($urandom_range(0, 1) == 0), ($urandom_range(0, 1) == 0), W'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
